// File: rtl/rtype_encoder.sv
// rtype_encoder: maps an ALU control code plus register fields onto a MIPS
// R-type instruction word and buffers up to four words in a small FIFO.
// Illegal control codes are rejected with a one-cycle err pulse.
module rtype_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_cntl,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [7:0]  accept_cnt,
  output logic [7:0]  illegal_cnt
);

  logic [31:0] mem [4];
  logic [1:0]  wptr;
  logic [1:0]  rptr;
  logic [2:0]  count;
  logic [5:0]  funct;
  logic        legal;
  logic        take;
  logic        wr;
  logic        pop;

  // Decode the ALU control code into a funct field and a legality flag.
  always_comb begin
    funct = '0;
    legal = 1'b1;
    case (alu_cntl)
      4'b1010: funct = 6'h20;
      4'b0010: funct = 6'h21;
      4'b1110: funct = 6'h22;
      4'b0110: funct = 6'h23;
      4'b0000: funct = 6'h24;
      4'b0001: funct = 6'h25;
      4'b0011: funct = 6'h26;
      4'b1100: funct = 6'h27;
      4'b1101: funct = 6'h2A;
      4'b1111: funct = 6'h2B;
      default: legal = 1'b0;
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count < 3'd4);
  assign out_valid = (count != 3'd0);
  assign instr     = out_valid ? mem[rptr] : '0;

  assign take = in_valid && in_ready;
  assign wr   = take && legal;
  assign pop  = out_valid && out_ready;

  // FIFO storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr)
      mem[wptr] <= {6'b000000, rs, rt, rd, 5'b00000, funct};
  end

  // Pointers, occupancy, error pulse and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      err         <= 1'b0;
      accept_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      err <= take && !legal;
      if (wr)
        wptr <= wptr + 2'd1;
      if (pop)
        rptr <= rptr + 2'd1;
      case ({wr, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (wr && accept_cnt != '1)
        accept_cnt <= accept_cnt + 8'd1;
      if (take && !legal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rtype_encoder.sv
// Self-checking bench for rtype_encoder: a queue-based reference model is
// compared with every DUT output on every cycle, plus literal spot checks.
module tb_rtype_encoder;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [3:0]  alu_cntl;
  logic [4:0]  rs, rt, rd;
  logic        in_ready, out_valid, err;
  logic [31:0] instr;
  logic [7:0]  accept_cnt, illegal_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] q[$];
  logic        m_err;
  int          m_acc, m_ill;
  int          ftab[16];

  rtype_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cntl(alu_cntl), .rs(rs), .rt(rt), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err(err), .accept_cnt(accept_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output against it half a cycle later.
  task automatic step();
    bit rdy, push, popm;
    int f;
    @(posedge clk);
    rdy  = (q.size() < 4);
    push = in_valid && rdy;
    popm = (q.size() > 0) && out_ready;
    f    = ftab[alu_cntl];
    if (reset) begin
      q.delete();
      m_err = 1'b0;
      m_acc = 0;
      m_ill = 0;
    end else begin
      m_err = push && (f < 0);
      if (popm) void'(q.pop_front());
      if (push && f >= 0) begin
        q.push_back({6'd0, rs, rt, rd, 5'd0, f[5:0]});
        if (m_acc < 255) m_acc++;
      end
      if (push && f < 0 && m_ill < 255) m_ill++;
    end
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 4});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("instr", instr, (q.size() > 0) ? q[0] : 32'h0);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("accept_cnt", {24'd0, accept_cnt}, m_acc);
    chk("illegal_cnt", {24'd0, illegal_cnt}, m_ill);
  endtask

  task automatic drive(input bit v, input logic [3:0] c, input int s, input int t, input int d);
    in_valid = v;
    alu_cntl = c;
    rs = s[4:0];
    rt = t[4:0];
    rd = d[4:0];
  endtask

  function automatic logic [3:0] rand_legal();
    logic [3:0] c;
    do c = 4'($urandom_range(0, 15)); while (ftab[c] < 0);
    return c;
  endfunction

  initial begin
    logic [7:0] acc_snap;
    logic [5:0] exp_f [4];
    exp_f = '{6'h22, 6'h2A, 6'h27, 6'h2B};
    foreach (ftab[i]) ftab[i] = -1;
    ftab[4'b1010] = 'h20; ftab[4'b0010] = 'h21; ftab[4'b1110] = 'h22;
    ftab[4'b0110] = 'h23; ftab[4'b0000] = 'h24; ftab[4'b0001] = 'h25;
    ftab[4'b0011] = 'h26; ftab[4'b1100] = 'h27; ftab[4'b1101] = 'h2A;
    ftab[4'b1111] = 'h2B;
    m_err = 1'b0; m_acc = 0; m_ill = 0;

    // Reset state.
    reset = 1'b1; out_ready = 1'b0;
    drive(1'b1, 4'b1010, 1, 1, 1);
    step(); step();
    reset = 1'b0;
    drive(1'b0, 4'b0, 0, 0, 0);
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_instr", instr, 32'h0);

    // Single add.
    drive(1'b1, 4'b1010, 1, 2, 3);
    step();
    drive(1'b0, 4'b0, 0, 0, 0);
    chk("add_instr", instr, 32'h00221820);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_acc", {24'd0, accept_cnt}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Illegal code.
    drive(1'b1, 4'b0100, 1, 2, 3);
    step();
    drive(1'b0, 4'b0, 0, 0, 0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_cnt", {24'd0, illegal_cnt}, 32'd1);
    chk("ill_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("ill_err_drop", {31'd0, err}, 32'd0);

    // Fill to four, then an ignored fifth request, then ordered drain.
    drive(1'b1, 4'b1110, 1, 2, 4); step();
    drive(1'b1, 4'b1101, 1, 2, 5); step();
    drive(1'b1, 4'b1100, 1, 2, 6); step();
    drive(1'b1, 4'b1111, 1, 2, 7); step();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 4'b0100, 9, 9, 9); step();
    chk("full_ignored_err", {31'd0, err}, 32'd0);
    chk("full_ignored_ill", {24'd0, illegal_cnt}, 32'd1);
    // Pop while full with in_valid high: the freed slot is not offered yet.
    out_ready = 1'b1;
    drive(1'b1, 4'b1010, 9, 9, 9);
    chk("drain0", {26'd0, instr[5:0]}, {26'd0, exp_f[0]});
    step();
    drive(1'b0, 4'b0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      chk("drain", {26'd0, instr[5:0]}, {26'd0, exp_f[i]});
      step();
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Stream ten words with concurrent push and pop.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_legal(), $urandom_range(0, 31), $urandom_range(0, 31), i);
      step();
      chk("stream_occupancy", {31'd0, in_ready && (q.size() <= 1)}, 32'd1);
    end
    drive(1'b0, 4'b0, 0, 0, 0);
    step();

    // Mid-operation reset with three words buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_legal(), 3, 3, i); step();
    end
    reset = 1'b1; step(); reset = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_acc", {24'd0, accept_cnt}, 32'd0);
    chk("mrst_ill", {24'd0, illegal_cnt}, 32'd0);
    drive(1'b1, 4'b0000, 8, 9, 10); step();
    drive(1'b0, 4'b0, 0, 0, 0);
    chk("mrst_next", instr, 32'h0109_5024);
    out_ready = 1'b1; step();
    chk("mrst_alone", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      step();
    end
    reset = 1'b0;

    // Illegal counter saturation.
    out_ready = 1'b1;
    acc_snap = accept_cnt;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b1011, 1, 1, 1); step();
    end
    chk("sat_ill", {24'd0, illegal_cnt}, 32'd255);
    chk("sat_acc_unchanged", {24'd0, accept_cnt}, {24'd0, acc_snap});

    // Accept counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'b0010, 2, 2, 2); step();
    end
    chk("sat_acc", {24'd0, accept_cnt}, 32'd255);
    drive(1'b0, 4'b0, 0, 0, 0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
